rf68000_iack_ctrl: RTL and testbench

//  CPU-side interrupt acceptor: the initiator end of the interrupt controller's request/acknowledge protocol.

---
 rtl/rf68000_iack_pkg.sv | 22 ++
 rtl/rf68000_iack_ctrl_if.sv | 22 ++
 rtl/rf68000_irq_sync.sv | 45 ++++
 rtl/rf68000_iack_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rf68000_iack_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rf68000_iack_pkg.sv
// Shared types and constants for the rf68000 interrupt-acknowledge controller.
package rf68000_iack_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PEND,
      ST_IACK,
      ST_DONE,
      ST_RECOV
   } iack_state_t;

   localparam logic [7:0]  VEC_SPURIOUS = 8'd24;
   localparam logic [7:0]  VEC_AUTOBASE = 8'd24;
   localparam logic [2:0]  FC_IACK      = 3'b111;
   localparam logic [27:0] IACK_ADR_HI  = 28'hFFFFFFF;

   // Requested levels above 7 saturate to the highest 68k priority.
   function automatic logic [2:0] clamp_lvl(input logic [3:0] irq);
      return (irq > 4'd7) ? 3'd7 : irq[2:0];
   endfunction

endpackage

// File: rtl/rf68000_iack_ctrl_if.sv
// IACK bus interface: the acceptor is master, the vector responder is slave.
interface rf68000_iack_ctrl_if;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [2:0]  fc_o;
   logic [31:0] adr_o;
   logic [31:0] dat_i;
   logic        ack_i;
   logic        vpa_i;
   logic        err_i;

   modport master (
      output cyc_o, stb_o, we_o, fc_o, adr_o,
      input  dat_i, ack_i, vpa_i, err_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, fc_o, adr_o,
      output dat_i, ack_i, vpa_i, err_i
   );
endinterface

// File: rtl/rf68000_irq_sync.sv
// Multi-stage synchroniser for the interrupt controller outputs plus an nmi
// rising-edge detector on the synchronised nmi.
module rf68000_irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] irq_i,
   input  logic       nmi_i,
   input  logic [7:0] cause_i,
   input  logic [5:0] core_i,
   output logic [3:0] irq_s,
   output logic [7:0] cause_s,
   output logic [5:0] core_s,
   output logic       nmi_rise
);

   localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int W = 19;

   logic [W-1:0] r_sync [N];
   logic         r_nmi_prev;
   logic [W-1:0] w_in;
   logic [W-1:0] w_out;

   assign w_in  = {irq_i, nmi_i, cause_i, core_i};
   assign w_out = r_sync[N-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < N; i++) r_sync[i] <= '0;
         r_nmi_prev <= 1'b0;
      end else begin
         r_sync[0] <= w_in;
         for (int i = 1; i < N; i++) r_sync[i] <= r_sync[i-1];
         r_nmi_prev <= w_out[14];
      end
   end

   assign irq_s    = w_out[18:15];
   assign cause_s  = w_out[13:6];
   assign core_s   = w_out[5:0];
   assign nmi_rise = w_out[14] & ~r_nmi_prev;

endmodule

// File: rtl/rf68000_iack_ctrl.sv
// CPU-side interrupt acceptor: qualifies the synchronised request against the SR mask,
// runs the fc=111 IACK bus cycle and returns the vector. Option: RF68K_IACK_TIMEOUT_EN.
module rf68000_iack_ctrl
   import rf68000_iack_pkg::*;
#(
   parameter logic [5:0] CORE_ID     = 6'd0,
   parameter int         SYNC_STAGES = 2,
   parameter int         TIMEOUT_CYC = 255
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] irq_i,
   input  logic       nmi_i,
   input  logic [7:0] cause_i,
   input  logic [5:0] core_i,
   input  logic [2:0] imask_i,
   output logic       int_pend_o,
   input  logic       take_i,
   output logic [7:0] vec_o,
   output logic [2:0] lvl_o,
   output logic       vec_vld_o,
   input  logic       vec_rdy_i,
   rf68000_iack_ctrl_if.master bus
);

   iack_state_t r_state;
   logic        r_nmi_latch;
   logic [2:0]  r_lvl_q;
   logic        r_int_pend;
   logic [7:0]  r_vec;
   logic [2:0]  r_lvl;
   logic        r_vec_vld;
   logic        r_cyc;
   logic [2:0]  r_fc;
   logic [31:0] r_adr;

   logic [3:0]  w_irq_s;
   logic [5:0]  w_core_s;
   logic [7:0]  w_unused_cause;
   logic        w_nmi_rise;
   logic [2:0]  w_lvl_irq;
   logic [2:0]  w_lvl;
   logic        w_elig;
   logic        w_tmo;
   logic        w_resp;
   logic [7:0]  w_vec;
   logic        w_unused_dat;

   rf68000_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .irq_i    (irq_i),
      .nmi_i    (nmi_i),
      .cause_i  (cause_i),
      .core_i   (core_i),
      .irq_s    (w_irq_s),
      .cause_s  (w_unused_cause),
      .core_s   (w_core_s),
      .nmi_rise (w_nmi_rise)
   );

   assign w_unused_dat = ^bus.dat_i[31:8];

   // A latched nmi overrides whatever level the controller is presenting.
   assign w_lvl_irq = clamp_lvl(w_irq_s);
   assign w_lvl     = r_nmi_latch ? 3'd7 : w_lvl_irq;
   assign w_elig    = r_nmi_latch |
                      ((w_lvl_irq != 3'd0) && (w_core_s == CORE_ID) &&
                       ((w_lvl_irq == 3'd7) || (w_lvl_irq > imask_i)));

`ifdef RF68K_IACK_TIMEOUT_EN
   logic [7:0] r_tmo_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                  r_tmo_cnt <= '0;
      else if (r_state != ST_IACK) r_tmo_cnt <= '0;
      else                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
   end

   assign w_tmo = (r_state == ST_IACK) && (r_tmo_cnt == 8'(TIMEOUT_CYC - 1));
`else
   logic [7:0] w_unused_tmo;
   assign w_unused_tmo = 8'(TIMEOUT_CYC);
   assign w_tmo        = 1'b0;
`endif

   // Response priority err > ack > vpa; a timeout is reported as spurious.
   assign w_resp = bus.err_i | bus.ack_i | bus.vpa_i | w_tmo;
   assign w_vec  = bus.err_i ? VEC_SPURIOUS :
                   bus.ack_i ? bus.dat_i[7:0] :
                   bus.vpa_i ? (VEC_AUTOBASE + {5'd0, r_lvl_q}) :
                               VEC_SPURIOUS;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_nmi_latch <= 1'b0;
         r_lvl_q     <= '0;
         r_int_pend  <= 1'b0;
         r_vec       <= '0;
         r_lvl       <= '0;
         r_vec_vld   <= 1'b0;
         r_cyc       <= 1'b0;
         r_fc        <= '0;
         r_adr       <= '0;
      end else begin
         // A fresh edge wins over the clear so a coincident nmi is not lost.
         if (w_nmi_rise)
            r_nmi_latch <= 1'b1;
         else if (r_state == ST_PEND && w_elig && take_i && w_lvl == 3'd7)
            r_nmi_latch <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_elig) begin
                  r_state    <= ST_PEND;
                  r_int_pend <= 1'b1;
               end
            end
            ST_PEND: begin
               if (!w_elig) begin
                  r_state    <= ST_IDLE;
                  r_int_pend <= 1'b0;
               end else if (take_i) begin
                  r_state    <= ST_IACK;
                  r_int_pend <= 1'b0;
                  r_lvl_q    <= w_lvl;
                  r_cyc      <= 1'b1;
                  r_fc       <= FC_IACK;
                  r_adr      <= {IACK_ADR_HI, w_lvl, 1'b0};
               end
            end
            ST_IACK: begin
               if (w_resp) begin
                  r_state   <= ST_DONE;
                  r_cyc     <= 1'b0;
                  r_fc      <= '0;
                  r_adr     <= '0;
                  r_vec     <= w_vec;
                  r_lvl     <= r_lvl_q;
                  r_vec_vld <= 1'b1;
               end
            end
            ST_DONE: begin
               if (vec_rdy_i) begin
                  r_state   <= ST_RECOV;
                  r_vec_vld <= 1'b0;
               end
            end
            ST_RECOV: r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign int_pend_o = r_int_pend;
   assign vec_o      = r_vec;
   assign lvl_o      = r_lvl;
   assign vec_vld_o  = r_vec_vld;
   assign bus.cyc_o  = r_cyc;
   assign bus.stb_o  = r_cyc;
   assign bus.we_o   = 1'b0;
   assign bus.fc_o   = r_fc;
   assign bus.adr_o  = r_adr;

endmodule

// File: tb/tb_rf68000_iack_ctrl.sv
// Self-checking bench for rf68000_iack_ctrl: vector table plus hand-written corner sequences.
module tb_rf68000_iack_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] irq = '0;
   logic       nmi = 1'b0;
   logic [7:0] cause = 8'h5A;
   logic [5:0] core = '0;
   logic [2:0] imask = '0;
   logic       int_pend;
   logic       take = 1'b0;
   logic [7:0] vec;
   logic [2:0] lvl;
   logic       vec_vld;
   logic       vec_rdy = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [7:0] vec;
      logic [2:0] lvl;
   } exp_t;
   exp_t sb[$];

   // resp: 0 ack, 1 vpa, 2 err, 3 err+ack, 4 ack+vpa
   typedef struct {
      logic [3:0]  irq;
      logic [5:0]  core;
      logic [2:0]  imask;
      int          resp;
      logic [31:0] dat;
      logic        pend;
      logic [31:0] adr;
      logic [7:0]  vec;
      logic [2:0]  lvl;
   } vec_t;
   vec_t tbl[9];

   rf68000_iack_ctrl_if bus();

   rf68000_iack_ctrl #(.CORE_ID(6'd0), .SYNC_STAGES(2), .TIMEOUT_CYC(255)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .irq_i      (irq),
      .nmi_i      (nmi),
      .cause_i    (cause),
      .core_i     (core),
      .imask_i    (imask),
      .int_pend_o (int_pend),
      .take_i     (take),
      .vec_o      (vec),
      .lvl_o      (lvl),
      .vec_vld_o  (vec_vld),
      .vec_rdy_i  (vec_rdy),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   task automatic wait_pend(input string nm);
      for (int i = 0; i < 30 && int_pend !== 1'b1; i++) tick();
      chk({nm, "_pend"}, int_pend, 1);
   endtask

   task automatic drive_resp(input int resp, input logic [31:0] dat);
      bus.dat_i = dat;
      bus.ack_i = (resp == 0 || resp == 3 || resp == 4);
      bus.vpa_i = (resp == 1 || resp == 4);
      bus.err_i = (resp == 2 || resp == 3);
   endtask

   // Wait for the vector, pop the scoreboard and compare.
   task automatic collect(input string nm);
      exp_t e;
      for (int i = 0; i < 10 && vec_vld !== 1'b1; i++) tick();
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({nm, "_vld"}, vec_vld, 1);
         chk({nm, "_vec_lvl"}, {vec, lvl}, {e.vec, e.lvl});
      end
   endtask

   task automatic do_iack(input string nm, input logic [31:0] exp_adr, input int resp,
                          input logic [31:0] dat, input logic [7:0] exp_vec,
                          input logic [2:0] exp_lvl, input int hold, input logic [3:0] irq_during);
      wait_pend(nm);
      take = 1'b1;
      tick();
      take = 1'b0;
      chk({nm, "_bus"}, {bus.cyc_o, bus.stb_o, bus.we_o, bus.fc_o, bus.adr_o, int_pend},
          {1'b1, 1'b1, 1'b0, 3'b111, exp_adr, 1'b0});
      irq = irq_during;
      repeat (hold) tick();
      drive_resp(resp, dat);
      sb.push_back('{vec: exp_vec, lvl: exp_lvl});
      tick();
      drive_resp(-1, 32'h0);
      chk({nm, "_lat"}, {vec_vld, bus.cyc_o, bus.stb_o, bus.fc_o}, {1'b1, 1'b0, 1'b0, 3'b000});
      collect(nm);
   endtask

   task automatic release_vec(input string nm);
      irq = '0;
      nmi = 1'b0;
      repeat (3) tick();
      vec_rdy = 1'b1;
      tick();
      vec_rdy = 1'b0;
      chk({nm, "_rel"}, vec_vld, 0);
      repeat (4) tick();
   endtask

   task automatic no_pend(input string nm, input int cycles);
      logic seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         seen |= int_pend | bus.cyc_o;
      end
      chk({nm, "_nopend"}, seen, 0);
   endtask

   initial begin
      drive_resp(-1, 32'h0);
      tbl[0] = '{4'd5, 6'd0, 3'd3, 0, 32'h40404040, 1'b1, 32'hFFFFFFFA, 8'h40, 3'd5};
      tbl[1] = '{4'd4, 6'd0, 3'd0, 1, 32'h0,        1'b1, 32'hFFFFFFF8, 8'd28,  3'd4};
      tbl[2] = '{4'd4, 6'd0, 3'd0, 2, 32'h0,        1'b1, 32'hFFFFFFF8, 8'd24,  3'd4};
      tbl[3] = '{4'd9, 6'd0, 3'd7, 0, 32'h000000A5, 1'b1, 32'hFFFFFFFE, 8'hA5, 3'd7};
      tbl[4] = '{4'd2, 6'd0, 3'd3, 0, 32'h0,        1'b0, 32'h0,        8'h0,  3'd0};
      tbl[5] = '{4'd3, 6'd5, 3'd0, 0, 32'h0,        1'b0, 32'h0,        8'h0,  3'd0};
      tbl[6] = '{4'd1, 6'd0, 3'd0, 1, 32'h0,        1'b1, 32'hFFFFFFF2, 8'd25,  3'd1};
      tbl[7] = '{4'd7, 6'd0, 3'd7, 3, 32'h000000EE, 1'b1, 32'hFFFFFFFE, 8'd24,  3'd7};
      tbl[8] = '{4'd6, 6'd0, 3'd5, 4, 32'h1234563C, 1'b1, 32'hFFFFFFFC, 8'h3C, 3'd6};

      repeat (3) tick();
      chk("reset_outputs",
          {int_pend, vec, lvl, vec_vld, bus.cyc_o, bus.stb_o, bus.we_o, bus.fc_o, bus.adr_o}, '0);
      rst = 1'b0;
      tick();

      foreach (tbl[i]) begin
         irq   = tbl[i].irq;
         core  = tbl[i].core;
         imask = tbl[i].imask;
         if (tbl[i].pend) begin
            do_iack($sformatf("vec%0d", i), tbl[i].adr, tbl[i].resp, tbl[i].dat,
                    tbl[i].vec, tbl[i].lvl, i % 3, tbl[i].irq);
            release_vec($sformatf("vec%0d", i));
         end else begin
            no_pend($sformatf("vec%0d", i), 40);
            irq  = '0;
            core = '0;
            repeat (4) tick();
         end
      end

      // Masked level, then unmask; then withdraw while pending.
      irq = 4'd2; imask = 3'd3;
      no_pend("masked", 100);
      imask = 3'd1;
      begin
         int n = 0;
         while (int_pend !== 1'b1 && n < 3) begin tick(); n++; end
         chk("unmask_pend", int_pend, 1);
      end
      irq = '0;
      begin
         logic cyc_seen = 1'b0;
         for (int i = 0; i < 6; i++) begin tick(); cyc_seen |= bus.cyc_o; end
         chk("withdraw", {int_pend, cyc_seen}, 2'b00);
      end
      imask = 3'd0;

      // Nmi with full mask, no re-trigger while nmi stays high.
      imask = 3'd7;
      nmi = 1'b1;
      do_iack("nmi", 32'hFFFFFFFE, 1, 32'h0, 8'd31, 3'd7, 0, 4'd0);
      repeat (3) tick();
      vec_rdy = 1'b1; tick(); vec_rdy = 1'b0;
      no_pend("nmi_held", 20);
      nmi = 1'b0;
      imask = 3'd0;
      repeat (4) tick();

      // Nmi upgrades a lower pending level before take.
      irq = 4'd2;
      wait_pend("upg_pre");
      nmi = 1'b1;
      repeat (5) tick();
      do_iack("upg", 32'hFFFFFFFE, 0, 32'h00000077, 8'h77, 3'd7, 0, 4'd2);
      release_vec("upg");
      no_pend("upg_cleared", 10);

      // Level change during IACK ignored; nmi edge during DONE serviced next.
      irq = 4'd3;
      do_iack("frz", 32'hFFFFFFF6, 1, 32'h0, 8'd27, 3'd3, 4, 4'd6);
      irq = '0;
      nmi = 1'b1;
      repeat (4) tick();
      vec_rdy = 1'b1; tick(); vec_rdy = 1'b0;
      do_iack("nmi_done", 32'hFFFFFFFE, 1, 32'h0, 8'd31, 3'd7, 0, 4'd0);
      release_vec("nmi_done");

`ifdef RF68K_IACK_TIMEOUT_EN
      irq = 4'd5;
      wait_pend("tmo");
      take = 1'b1; tick(); take = 1'b0;
      repeat (254) tick();
      chk("tmo_wait", bus.cyc_o, 1);
      tick();
      chk("tmo_fire", {bus.cyc_o, vec_vld, vec}, {1'b0, 1'b1, 8'd24});
      release_vec("tmo");
`endif

      // Async reset in the middle of an IACK cycle.
      irq = 4'd5;
      wait_pend("rst");
      take = 1'b1; tick(); take = 1'b0;
      chk("rst_in_iack", bus.cyc_o, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async",
          {int_pend, vec, lvl, vec_vld, bus.cyc_o, bus.stb_o, bus.we_o, bus.fc_o, bus.adr_o}, '0);
      irq = '0;
      repeat (3) tick();
      rst = 1'b0;
      no_pend("post_rst", 10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
